// File: rtl/cpu_clk_gen.sv
// Programmable 6502 PHI0 generator: run-time divisor switched at period boundaries,
// stretchable high phase with forced release, and one-cycle edge-anticipation strobes.
module cpu_clk_gen #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 8,
    parameter int MAX_STRETCH = 255
) (
    input  logic                 CLK_SRC,
    input  logic                 RST,
    input  logic [CNT_WIDTH-1:0] DIV_IN,
    input  logic                 DIV_LOAD,
    input  logic                 STRETCH,
    output logic                 PHI0,
    output logic                 PHI_RISE,
    output logic                 PHI_FALL,
    output logic [CNT_WIDTH-1:0] DIV_CUR,
    output logic                 STRETCHING,
    output logic                 STRETCH_TO
);

    localparam int SW = (MAX_STRETCH < 2) ? 1 : $clog2(MAX_STRETCH + 1);
    localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);
    localparam logic [SW-1:0]        SMAX    = SW'(MAX_STRETCH);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_cur_q, div_cur_d;
    logic [CNT_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                 pend_q, pend_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic                 phi_q, phi_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 stretching_q, stretching_d;
    logic                 sto_q, sto_d;

    logic [CNT_WIDTH-1:0] hi_s, hi_next_s;
    logic                 hi_end_s, wrap_s, hold_s, swap_s;

    // Next-state: counter, divisor hand-over, stretch bookkeeping and output strobes.
    always_comb begin
        hi_s      = div_cur_q >> 1;
        hi_end_s  = (cnt_q == hi_s - ONE);
        wrap_s    = (cnt_q == div_cur_q - ONE);
        hold_s    = hi_end_s && STRETCH && (scnt_q < SMAX);
        swap_s    = wrap_s && pend_q;

        cnt_d        = cnt_q;
        div_cur_d    = div_cur_q;
        div_pend_d   = div_pend_q;
        pend_d       = pend_q;
        scnt_d       = '0;
        stretching_d = hold_s;
        sto_d        = hi_end_s && STRETCH && !hold_s;

        if (hold_s) begin
            cnt_d  = cnt_q;
            scnt_d = scnt_q + SW'(1);
        end else if (wrap_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        if (swap_s) begin
            div_cur_d = div_pend_q;
        end else begin
            div_cur_d = div_cur_q;
        end

        // A load on the boundary edge wins over the clear so it lands one period later.
        if (DIV_LOAD) begin
            pend_d     = 1'b1;
            div_pend_d = (DIV_IN < TWO) ? TWO : DIV_IN;
        end else if (swap_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        hi_next_s = div_cur_d >> 1;
        phi_d     = (cnt_d < hi_next_s);
        rise_d    = (cnt_d == div_cur_d - ONE);
        fall_d    = (cnt_d == hi_next_s - ONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_SRC) begin
        if (RST) begin
            cnt_q        <= DIV_RST - ONE;
            div_cur_q    <= DIV_RST;
            div_pend_q   <= DIV_RST;
            pend_q       <= 1'b0;
            scnt_q       <= '0;
            phi_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            stretching_q <= 1'b0;
            sto_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_cur_q    <= div_cur_d;
            div_pend_q   <= div_pend_d;
            pend_q       <= pend_d;
            scnt_q       <= scnt_d;
            phi_q        <= phi_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            stretching_q <= stretching_d;
            sto_q        <= sto_d;
        end
    end

    assign PHI0       = phi_q;
    assign PHI_RISE   = rise_q;
    assign PHI_FALL   = fall_q;
    assign DIV_CUR    = div_cur_q;
    assign STRETCHING = stretching_q;
    assign STRETCH_TO = sto_q;

endmodule
